result_ddr_writer: RTL

RESULT_DDR_WRITER -- requirements
Module: result_ddr_writer

---
 rtl/result_ddr_writer_if.sv | 41 ++++
 rtl/result_ddr_writer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/result_ddr_writer_if.sv
// Bus bundle for result_ddr_writer: command inputs, buffer read port, DDR FIFO push port, status.
// The slave modport is the writer's view; the master modport is the environment's view.
interface result_ddr_writer_if #(
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned DDR_DATA_LEN = 256,
  parameter int unsigned ADDR_LEN     = 16,
  parameter int unsigned DATA_LEN     = 64,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned BUFFER_NUM   = 32,
  parameter int unsigned GROUPS       = BUFFER_NUM / (DDR_DATA_LEN / DATA_LEN),
  parameter int unsigned GW           = (GROUPS > 1) ? $clog2(GROUPS) : 1
);
  logic                    conf;
  logic [SINGLE_LEN-1:0]   word_num;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr;
  logic [ADDR_LEN-1:0]     rb_st_addr;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic                    rb_rea;
  logic [GW-1:0]           rb_grp;
  logic [ADDR_LEN-1:0]     rb_addr;
  logic [DDR_DATA_LEN-1:0] rb_data;
  logic                    ddr_fifo_full;
  logic                    ddr_fifo_wr;
  logic [DDR_DATA_LEN-1:0] ddr_fifo_data;
  logic                    idle;
  logic                    done;

  modport slave (
    input  conf, word_num, ddr_st_addr, rb_st_addr, rb_data, ddr_fifo_full,
    output ddr_st_addr_out, ddr_len, ddr_conf, rb_rea, rb_grp, rb_addr,
           ddr_fifo_wr, ddr_fifo_data, idle, done
  );

  modport master (
    output conf, word_num, ddr_st_addr, rb_st_addr, rb_data, ddr_fifo_full,
    input  ddr_st_addr_out, ddr_len, ddr_conf, rb_rea, rb_grp, rb_addr,
           ddr_fifo_wr, ddr_fifo_data, idle, done
  );
endinterface

// File: rtl/result_ddr_writer.sv
// Streams GROUPS*word_num buffer words (group-major) into the DDR write FIFO via a 2-entry skid queue.
// Optional macro WRITER_LANE_REVERSE_EN reverses the DATA_LEN lanes of each pushed word.
module result_ddr_writer #(
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned DDR_DATA_LEN = 256,
  parameter int unsigned ADDR_LEN     = 16,
  parameter int unsigned DATA_LEN     = 64,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned BUFFER_NUM   = 32,
  parameter int unsigned GROUPS       = BUFFER_NUM / (DDR_DATA_LEN / DATA_LEN)
) (
  input logic                clk,
  input logic                rst,
  result_ddr_writer_if.slave bus
);
  localparam int unsigned GW    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned LANES = DDR_DATA_LEN / DATA_LEN;
  localparam logic [SINGLE_LEN-1:0] LenPerWord = SINGLE_LEN'(GROUPS * (DDR_DATA_LEN / 8));

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [SINGLE_LEN-1:0]   word_num_q, word_num_d;
  logic [ADDR_LEN-1:0]     rb_st_addr_q, rb_st_addr_d;
  logic [DDR_ADDR_LEN-1:0] ddr_addr_q, ddr_addr_d;
  logic [SINGLE_LEN-1:0]   ddr_len_q, ddr_len_d;
  logic                    ddr_conf_q, ddr_conf_d;
  logic                    done_q, done_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [SINGLE_LEN-1:0]   cnt_q, cnt_d;
  logic                    infl_q, infl_d;
  logic [1:0]              occ_q, occ_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [DDR_DATA_LEN-1:0] mem_q [2];
  logic [DDR_DATA_LEN-1:0] mem_d [2];

  logic                    pop;
  logic                    rea;
  logic [2:0]              load;
  logic                    drain_exit;
  logic [DDR_DATA_LEN-1:0] head;
  logic [DDR_DATA_LEN-1:0] fifo_data;

  // Occupancy after this cycle's pop plus reads in flight; keeps one read per cycle when draining.
  assign pop        = (occ_q != 2'd0) && !bus.ddr_fifo_full;
  assign load       = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign rea        = (state_q == ST_RUN) && (load < 3'd2);
  assign drain_exit = (state_q == ST_DRAIN) && (occ_q == 2'd0) && !infl_q;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    word_num_d   = word_num_q;
    rb_st_addr_d = rb_st_addr_q;
    ddr_addr_d   = ddr_addr_q;
    ddr_len_d    = ddr_len_q;
    ddr_conf_d   = 1'b0;
    done_d       = 1'b0;
    grp_d        = grp_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.conf) begin
          if (bus.word_num != '0) begin
            state_d      = ST_RUN;
            word_num_d   = bus.word_num;
            rb_st_addr_d = bus.rb_st_addr;
            ddr_addr_d   = bus.ddr_st_addr;
            ddr_len_d    = bus.word_num * LenPerWord;
            ddr_conf_d   = 1'b1;
            grp_d        = '0;
            cnt_d        = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rea) begin
          if (cnt_q == word_num_q - SINGLE_LEN'(1)) begin
            cnt_d = '0;
            grp_d = grp_q + GW'(1);
            if (grp_q == GW'(GROUPS - 1)) state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + SINGLE_LEN'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    infl_d   = rea;
    occ_d    = occ_q + {1'b0, infl_q} - {1'b0, pop};
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ infl_q;
    mem_d    = mem_q;
    if (infl_q) mem_d[wr_ptr_q] = bus.rb_data;
  end

`ifdef WRITER_LANE_REVERSE_EN
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      fifo_data[i*DATA_LEN +: DATA_LEN] = head[(int'(LANES) - 1 - i)*DATA_LEN +: DATA_LEN];
    end
  end
`else
  always_comb begin
    fifo_data = head;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_num_q   <= '0;
      rb_st_addr_q <= '0;
      ddr_addr_q   <= '0;
      ddr_len_q    <= '0;
      ddr_conf_q   <= 1'b0;
      done_q       <= 1'b0;
      grp_q        <= '0;
      cnt_q        <= '0;
      infl_q       <= 1'b0;
      occ_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
    end else begin
      state_q      <= state_d;
      word_num_q   <= word_num_d;
      rb_st_addr_q <= rb_st_addr_d;
      ddr_addr_q   <= ddr_addr_d;
      ddr_len_q    <= ddr_len_d;
      ddr_conf_q   <= ddr_conf_d;
      done_q       <= done_d;
      grp_q        <= grp_d;
      cnt_q        <= cnt_d;
      infl_q       <= infl_d;
      occ_q        <= occ_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_q[0]     <= mem_d[0];
      mem_q[1]     <= mem_d[1];
    end
  end

  assign bus.ddr_st_addr_out = ddr_addr_q;
  assign bus.ddr_len         = ddr_len_q;
  assign bus.ddr_conf        = ddr_conf_q;
  assign bus.rb_rea          = rea;
  assign bus.rb_grp          = grp_q;
  assign bus.rb_addr         = rb_st_addr_q + ADDR_LEN'(cnt_q);
  assign bus.ddr_fifo_wr     = pop;
  assign bus.ddr_fifo_data   = fifo_data;
  assign bus.idle            = (state_q == ST_IDLE);
  assign bus.done            = done_q | drain_exit;
endmodule
